// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one single-port SRAM.
// Optional starvation guard for the instruction port: define ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [29:0]   IADDR,
  output logic          IGNT,
  output logic          IVALID,
  output logic [31:0]   INSTR,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic          DGNT,
  output logic          DVALID,
  output logic [31:0]   DRDATA,
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [31:0]   M_DI,
  input  logic [31:0]   M_DOUT
);

  typedef enum logic [1:0] {TAG_NONE, TAG_I_RD, TAG_D_RD, TAG_D_WR} tag_t;

  tag_t tag_reg, tag_next;
  logic force_i;

  // Only the word-address slice reaches the SRAM; the rest wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IADDR[29:AW+2], IADDR[1:0], DADDR[29:AW+2], DADDR[1:0]};

`ifdef ARB_FAIRNESS_EN
  logic [3:0] starve_reg, starve_next;

  assign force_i = (starve_reg == 4'(STARVE_MAX));

  always_comb begin
    starve_next = starve_reg;
    if (!IREQ || IGNT)
      starve_next = 4'd0;
    else if (starve_reg != 4'(STARVE_MAX))
      starve_next = starve_reg + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      starve_reg <= 4'd0;
    else
      starve_reg <= starve_next;
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    IGNT     = 1'b0;
    DGNT     = 1'b0;
    M_CSN    = 1'b1;
    M_WEN    = 1'b1;
    M_A      = '0;
    M_DI     = 32'd0;
    tag_next = TAG_NONE;
    if (!RST) begin
      // Data wins ties unless the instruction port has hit its starvation limit.
      if (DREQ && !(IREQ && force_i))
        DGNT = 1'b1;
      else if (IREQ)
        IGNT = 1'b1;
    end
    if (DGNT) begin
      M_CSN    = 1'b0;
      M_WEN    = ~DRW;
      M_A      = DADDR[AW+1:2];
      M_DI     = DWDATA;
      tag_next = DRW ? TAG_D_WR : TAG_D_RD;
    end else if (IGNT) begin
      M_CSN    = 1'b0;
      M_A      = IADDR[AW+1:2];
      tag_next = TAG_I_RD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      tag_reg <= TAG_NONE;
    else
      tag_reg <= tag_next;
  end

  // Gating with RST drops the in-flight response in the cycle reset rises.
  always_comb begin
    IVALID = !RST && (tag_reg == TAG_I_RD);
    DVALID = !RST && ((tag_reg == TAG_D_RD) || (tag_reg == TAG_D_WR));
    INSTR  = IVALID ? M_DOUT : 32'd0;
    DRDATA = (!RST && (tag_reg == TAG_D_RD)) ? M_DOUT : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_mem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ireq, dreq, drw;
  logic [29:0]   iaddr, daddr;
  logic [31:0]   dwdata;
  logic          ignt, ivalid, dgnt, dvalid;
  logic [31:0]   instr, drdata;
  logic          m_csn, m_wen;
  logic [AW-1:0] m_a;
  logic [31:0]   m_di, m_dout;

  logic [31:0]   mem [0:1023];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
    .CLK(clk), .RST(rst),
    .IREQ(ireq), .IADDR(iaddr), .IGNT(ignt), .IVALID(ivalid), .INSTR(instr),
    .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
    .DGNT(dgnt), .DVALID(dvalid), .DRDATA(drdata),
    .M_CSN(m_csn), .M_WEN(m_wen), .M_A(m_a), .M_DI(m_di), .M_DOUT(m_dout)
  );

  always @(posedge clk) begin
    if (!m_csn) begin
      if (!m_wen) mem[m_a] <= m_di;
      else        m_dout   <= mem[m_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_i;
    for (int j = 0; j < 1024; j++) mem[j] = 32'hC0DE0000 | 32'(j);
    mem[4] = 32'h12345678;
    m_dout = 32'd0;
    rst = 1'b1; ireq = 1'b1; dreq = 1'b0; drw = 1'b0;
    iaddr = 30'h10; daddr = 30'h0; dwdata = 32'd0;

    // Reset state, with a request pending that must not be granted
    @(negedge clk);
    check("rst_ignt", 32'(ignt), 32'd0);
    check("rst_dgnt", 32'(dgnt), 32'd0);
    check("rst_valid", {30'd0, ivalid, dvalid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_drdata", drdata, 32'd0);
    check("rst_mem_ctl", {30'd0, m_csn, m_wen}, 32'd3);
    check("rst_m_a", 32'(m_a), 32'd0);
    check("rst_m_di", m_di, 32'd0);
    next_cycle();
    rst = 1'b0; ireq = 1'b0;
    next_cycle();

    // Instruction fetch from word 4
    ireq = 1'b1; iaddr = 30'h10;
    @(negedge clk);
    check("if_gnt", {30'd0, ignt, dgnt}, 32'd2);
    check("if_mem_ctl", {30'd0, m_csn, m_wen}, 32'd1);
    check("if_m_a", 32'(m_a), 32'd4);
    next_cycle();
    ireq = 1'b0;
    @(negedge clk);
    check("if_ivalid", 32'(ivalid), 32'd1);
    check("if_instr", instr, 32'h12345678);
    check("if_idle_csn", 32'(m_csn), 32'd1);
    next_cycle();

    // Write then read back word 8; upper address bits must be ignored on the read
    dreq = 1'b1; drw = 1'b1; daddr = 30'h20; dwdata = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_gnt", {30'd0, ignt, dgnt}, 32'd1);
    check("wr_mem_ctl", {30'd0, m_csn, m_wen}, 32'd0);
    check("wr_m_a", 32'(m_a), 32'd8);
    check("wr_m_di", m_di, 32'hDEADBEEF);
    next_cycle();
    drw = 1'b0; daddr = 30'h20 | 30'h1000;
    @(negedge clk);
    check("wr_ack_dvalid", 32'(dvalid), 32'd1);
    check("wr_ack_drdata", drdata, 32'd0);
    check("rd_m_a_wrap", 32'(m_a), 32'd8);
    check("rd_m_wen", 32'(m_wen), 32'd1);
    next_cycle();
    dreq = 1'b0;
    @(negedge clk);
    check("rd_dvalid", 32'(dvalid), 32'd1);
    check("rd_drdata", drdata, 32'hDEADBEEF);
    check("rd_ivalid", 32'(ivalid), 32'd0);
    next_cycle();

    // Contention for three cycles: data wins
    ireq = 1'b1; iaddr = 30'h10; dreq = 1'b1; drw = 1'b0; daddr = 30'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("prio_gnt%0d", k), {30'd0, ignt, dgnt}, 32'd1);
      next_cycle();
    end
    dreq = 1'b0;
    @(negedge clk);
    check("prio_release_gnt", {30'd0, ignt, dgnt}, 32'd2);
    next_cycle();

    // Twelve cycles of contention from a cleared starvation state
    dreq = 1'b1;
    for (int k = 0; k < 12; k++) begin
`ifdef ARB_FAIRNESS_EN
      exp_i = (k % 5 == 4);
`else
      exp_i = 1'b0;
`endif
      @(negedge clk);
      check($sformatf("fair_gnt%0d", k), {30'd0, ignt, dgnt}, exp_i ? 32'd2 : 32'd1);
      next_cycle();
    end
    ireq = 1'b0; dreq = 1'b0;
    next_cycle();

    // Reset arriving the cycle after an instruction grant discards the response
    ireq = 1'b1; iaddr = 30'h10;
    @(negedge clk);
    check("mid_rst_gnt", 32'(ignt), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ivalid_n1", 32'(ivalid), 32'd0);
    check("mid_rst_outs", {instr[15:0], 12'd0, ignt, dgnt, m_csn, m_wen}, 32'd3);
    next_cycle();
    rst = 1'b0; ireq = 1'b0;
    @(negedge clk);
    check("mid_rst_ivalid_n2", 32'(ivalid), 32'd0);
    next_cycle();
    ireq = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 32'(ignt), 32'd1);
    next_cycle();
    ireq = 1'b0;
    @(negedge clk);
    check("post_rst_instr", instr, 32'h12345678);
    next_cycle();

    // Alternating single-port reads every cycle, words 60..79
    for (int i = 0; i <= 20; i++) begin
      ireq  = (i < 20) && (i % 2 == 0);
      dreq  = (i < 20) && (i % 2 == 1);
      drw   = 1'b0;
      iaddr = 30'((60 + i) * 4);
      daddr = 30'((60 + i) * 4);
      @(negedge clk);
      if (i < 20)
        check($sformatf("alt_gnt%0d", i), {30'd0, ignt, dgnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i > 0) begin
        exp_i = ((i - 1) % 2 == 0);
        check($sformatf("alt_valid%0d", i), {30'd0, ivalid, dvalid}, exp_i ? 32'd2 : 32'd1);
        check($sformatf("alt_data%0d", i), exp_i ? instr : drdata, 32'hC0DE0000 | 32'(60 + i - 1));
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
